// File: rtl/store_byte_narrower.sv
// Narrows a store value to byte/half/word and writes it LSB-first, one byte per acked bus transfer.
// Latency nbytes+1 cycles with ack high; req_ready low while busy, bus outputs held until bus_ack.
module store_byte_narrower #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [LANE_WIDTH-1:0] bus_byte,
  input  logic                  bus_ack,
  output logic                  done,
  output logic                  narrow_ovf,
  output logic                  misalign_err
);

  localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int NB_W   = $clog2(NLANES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NB_W-1:0]       nbytes_q, nbytes_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [LANE_WIDTH-1:0] bus_byte_q, bus_byte_d;
  logic                  done_q, done_d;
  logic                  narrow_ovf_q, narrow_ovf_d;
  logic                  misalign_err_q, misalign_err_d;

  logic [IDX_W-1:0]      idx_inc;
  logic                  last_byte;

  function automatic logic [NB_W-1:0] size_bytes(input logic [1:0] sz);
    logic [NB_W-1:0] nb;
    case (sz)
      2'b00:   nb = NB_W'(1);
      2'b01:   nb = NB_W'(2);
      default: nb = NB_W'(NLANES);
    endcase
    return nb;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic [1:0]            sz);
    logic bad;
    case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Every discarded bit must replicate the sign bit of the kept portion.
  function automatic logic narrow_overflow(input logic [DATA_WIDTH-1:0] d,
                                           input logic [NB_W-1:0]       nb);
    logic ovf;
    logic sgn;
    int   keep;
    ovf  = 1'b0;
    keep = LANE_WIDTH * int'(nb);
    if (keep > 0 && keep < DATA_WIDTH) begin
      sgn = d[keep-1];
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i >= keep && d[i] != sgn) begin
          ovf = 1'b1;
        end
      end
    end
    return ovf;
  endfunction

  function automatic logic [LANE_WIDTH-1:0] lane_of(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [IDX_W-1:0]      i);
    return d[LANE_WIDTH*int'(i) +: LANE_WIDTH];
  endfunction

  assign idx_inc   = idx_q + IDX_W'(1);
  assign last_byte = (NB_W'(idx_q) == (nbytes_q - NB_W'(1)));

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    data_d         = data_q;
    nbytes_d       = nbytes_q;
    idx_d          = idx_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_byte_d     = bus_byte_q;
    done_d         = 1'b0;
    narrow_ovf_d   = 1'b0;
    misalign_err_d = 1'b0;
    req_ready      = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_addr, req_size)) begin
            state_d        = S_ERR;
            misalign_err_d = 1'b1;
          end else begin
            state_d    = S_WRITE;
            base_d     = req_addr;
            data_d     = req_data;
            nbytes_d   = size_bytes(req_size);
            idx_d      = '0;
            bus_we_d   = 1'b1;
            bus_addr_d = req_addr;
            bus_byte_d = req_data[LANE_WIDTH-1:0];
          end
        end
      end
      S_WRITE: begin
        if (bus_ack) begin
          if (last_byte) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            narrow_ovf_d = narrow_overflow(data_q, nbytes_q);
            idx_d        = '0;
            bus_we_d     = 1'b0;
            bus_addr_d   = '0;
            bus_byte_d   = '0;
          end else begin
            // Address arithmetic wraps naturally at the top of the address space.
            idx_d      = idx_inc;
            bus_addr_d = base_q + ADDR_WIDTH'(idx_inc);
            bus_byte_d = lane_of(data_q, idx_inc);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      data_q         <= '0;
      nbytes_q       <= '0;
      idx_q          <= '0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_byte_q     <= '0;
      done_q         <= 1'b0;
      narrow_ovf_q   <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      data_q         <= data_d;
      nbytes_q       <= nbytes_d;
      idx_q          <= idx_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_byte_q     <= bus_byte_d;
      done_q         <= done_d;
      narrow_ovf_q   <= narrow_ovf_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_byte     = bus_byte_q;
  assign done         = done_q;
  assign narrow_ovf   = narrow_ovf_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_store_byte_narrower.sv
// Bench for store_byte_narrower: vector table with scoreboarded bus transfers and completions,
// plus sequences for back-to-back requests, ack stalls and reset mid-store.
module tb_store_byte_narrower;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_byte;
  logic        bus_ack;
  logic        done;
  logic        narrow_ovf;
  logic        misalign_err;

  store_byte_narrower #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LANE_WIDTH(8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_byte    (bus_byte),
    .bus_ack     (bus_ack),
    .done        (done),
    .narrow_ovf  (narrow_ovf),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        err;
    logic        ovf;
    int          nb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
  } xfer_t;

  typedef struct {
    logic err;
    logic ovf;
  } cmpl_t;

  vec_t  vecs[14];
  xfer_t xq[$];
  cmpl_t cq[$];
  int    checks = 0;
  int    errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input int nb,
                          input logic err, input logic ovf);
    logic [31:0] d;
    xfer_t       x;
    cmpl_t       c;
    d = data;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        x.addr = addr + 32'(i);
        x.b    = d[8*i +: 8];
        xq.push_back(x);
      end
    end
    c.err = err;
    c.ovf = ovf;
    cq.push_back(c);
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (bus_we) begin
          if (xq.size() == 0) begin
            check("unexpected_we", 32'(bus_we), 32'd0);
          end else begin
            check("bus_addr", bus_addr, xq[0].addr);
            check("bus_byte", 32'(bus_byte), 32'(xq[0].b));
            if (bus_ack) void'(xq.pop_front());
          end
        end
        if (done || misalign_err) begin
          check("done_err_exclusive", 32'(done & misalign_err), 32'd0);
          if (cq.size() == 0) begin
            check("unexpected_completion", 32'(done | misalign_err), 32'd0);
          end else begin
            check("completion_kind", 32'(misalign_err), 32'(cq[0].err));
            if (done) check("narrow_ovf", 32'(narrow_ovf), 32'(cq[0].ovf));
            void'(cq.pop_front());
          end
        end else if (narrow_ovf) begin
          check("ovf_without_done", 32'(narrow_ovf), 32'd0);
        end
      end
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK);
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (xq.size() == 0 && cq.size() == 0 && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 32'(xq.size() + cq.size()), 32'd0);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    req_valid = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    int lat;
    int exp_lat;
    lat     = 0;
    exp_lat = v.err ? 1 : v.nb + 1;
    wait_ready();
    drive_req(v.addr, v.data, v.size);
    @(posedge CLK);
    push_exp(v.addr, v.data, v.nb, v.err, v.ovf);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (done || misalign_err) begin
        lat = c;
        check("ready_during_completion", 32'(req_ready), 32'd0);
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(negedge CLK);
    check("ready_after_completion", 32'(req_ready), 32'd1);
    wait_idle();
  endtask

  initial begin
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    //               addr          data          size   err   ovf   nb
    vecs[0]  = '{32'h0000_0100, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 4};
    vecs[1]  = '{32'h0000_0007, 32'hFFFF_FF80, 2'b00, 1'b0, 1'b0, 1};
    vecs[2]  = '{32'h0000_0008, 32'h0000_0180, 2'b00, 1'b0, 1'b1, 1};
    vecs[3]  = '{32'h0000_0101, 32'h0000_1111, 2'b01, 1'b1, 1'b0, 0};
    vecs[4]  = '{32'h0000_0000, 32'h2222_2222, 2'b11, 1'b1, 1'b0, 0};
    vecs[5]  = '{32'h0000_0002, 32'h3333_3333, 2'b10, 1'b1, 1'b0, 0};
    vecs[6]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 4};
    vecs[7]  = '{32'h0000_0010, 32'hFFFF_8001, 2'b01, 1'b0, 1'b0, 2};
    vecs[8]  = '{32'h0000_0012, 32'h0000_7FFF, 2'b01, 1'b0, 1'b0, 2};
    vecs[9]  = '{32'h0000_0014, 32'h0001_8000, 2'b01, 1'b0, 1'b1, 2};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_007F, 2'b00, 1'b0, 1'b0, 1};
    vecs[11] = '{32'h0000_0003, 32'hFFFF_FFFF, 2'b01, 1'b1, 1'b0, 0};
    vecs[12] = '{32'h0000_0002, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 2};
    vecs[13] = '{32'h0000_0020, 32'h8000_0000, 2'b10, 1'b0, 1'b0, 4};

    RST       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    bus_ack   = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_byte", 32'(bus_byte), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_narrow_ovf", 32'(narrow_ovf), 32'd0);
    check("rst_misalign_err", 32'(misalign_err), 32'd0);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back: requester holds the next request while the unit is busy.
    wait_ready();
    drive_req(32'h0000_0030, 32'h0000_0055, 2'b00);
    @(posedge CLK);
    push_exp(32'h0000_0030, 32'h0000_0055, 1, 1'b0, 1'b0);
    #1;
    drive_req(32'h0000_0032, 32'h0000_1234, 2'b01);
    push_exp(32'h0000_0032, 32'h0000_1234, 2, 1'b0, 1'b0);
    @(negedge CLK);
    check("b2b_ready_c1", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("b2b_ready_c2", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("b2b_ready_c3", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    wait_idle();

    // Stalled half store: ack low three cycles per byte; monitor checks hold stability.
    bus_ack = 1'b0;
    wait_ready();
    drive_req(32'h0000_0200, 32'h0000_ABCD, 2'b01);
    @(posedge CLK);
    push_exp(32'h0000_0200, 32'h0000_ABCD, 2, 1'b0, 1'b1);
    #1;
    req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      repeat (3) @(posedge CLK);
      #1;
      check("stall_we_held", 32'(bus_we), 32'd1);
      bus_ack = 1'b1;
      @(posedge CLK);
      #1;
      bus_ack = 1'b0;
    end
    wait_idle();
    bus_ack = 1'b1;

    // Reset while the third byte of a word is on the bus.
    wait_ready();
    drive_req(32'h0000_0040, 32'h1122_3344, 2'b10);
    @(posedge CLK);
    push_exp(32'h0000_0040, 32'h1122_3344, 4, 1'b0, 1'b0);
    #1;
    req_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("abort_pre_addr", bus_addr, 32'h0000_0042);
    check("abort_pre_we", 32'(bus_we), 32'd1);
    #1;
    RST = 1'b0;
    xq.delete();
    cq.delete();
    #1;
    check("abort_we", 32'(bus_we), 32'd0);
    check("abort_addr", bus_addr, 32'd0);
    check("abort_byte", 32'(bus_byte), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_we_after", 32'(bus_we), 32'd0);
    repeat (4) @(posedge CLK);

    wait_idle();
    check("final_xfer_queue", 32'(xq.size()), 32'd0);
    check("final_cmpl_queue", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
